// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, timing defaults and helpers
// for the alarm sequencer slice.
package alarm_pkg;

   localparam int MAX_REQ = 32;

   localparam int DEF_N_REQ      = 3;
   localparam int DEF_TICK_DIV   = 50000;
   localparam int DEF_ON_TICKS   = 200;
   localparam int DEF_OFF_TICKS  = 200;
   localparam int DEF_BURSTS     = 5;
   localparam int DEF_GAP_TICKS  = 1000;
   localparam int DEF_MAX_ROUNDS = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // Lowest set bit kept, all others cleared (index 0 wins).
   function automatic logic [MAX_REQ-1:0] pri_onehot(
      input logic [MAX_REQ-1:0] v
   );
      return v & (~v + 1'b1);
   endfunction

endpackage

// File: rtl/alarm_if.sv
// alarm_if: request/acknowledge inputs and enable outputs
// between alarm sources and the sequencer.
interface alarm_if #(
   parameter int N_REQ = alarm_pkg::DEF_N_REQ
);

   logic [N_REQ-1:0] req;
   logic             ack;
   logic             alarm_en;
   logic             light_en;
   logic [N_REQ-1:0] grant;
   logic             busy;
   logic             timeout;

   modport master (
      output req,
      output ack,
      input  alarm_en,
      input  light_en,
      input  grant,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  ack,
      output alarm_en,
      output light_en,
      output grant,
      output busy,
      output timeout
   );

endinterface

// File: rtl/alarm_tick_gen.sv
// alarm_tick_gen: divides clk into a 1-cycle tick every
// TICK_DIV cycles; clr restarts the period.
module alarm_tick_gen
   import alarm_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(TICK_DIV - 1));

   // Free-running divider, restarted on reset, clear or wrap.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: fixed-priority arbiter driving one beeper
// and one breathing light with a burst/round cadence.
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int ON_TICKS   = DEF_ON_TICKS,
   parameter int OFF_TICKS  = DEF_OFF_TICKS,
   parameter int BURSTS     = DEF_BURSTS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
   input  logic   clk,
   input  logic   rst,
   alarm_if.slave bus
);

   localparam int MAX_OF =
      (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_T =
      (MAX_OF > GAP_TICKS) ? MAX_OF : GAP_TICKS;
   localparam int TW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
   localparam int BW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
   localparam int RW = $clog2(MAX_ROUNDS + 1);

   state_t           state;
   state_t           state_n;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] grant_n;
   logic [N_REQ-1:0] mute;
   logic [N_REQ-1:0] mute_set;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] winner;
   logic [TW-1:0]    tick_cnt;
   logic [TW-1:0]    tick_cnt_n;
   logic [BW-1:0]    burst_cnt;
   logic [BW-1:0]    burst_cnt_n;
   logic [RW-1:0]    round_cnt;
   logic [RW-1:0]    round_cnt_n;
   logic [RW-1:0]    round_inc;
   logic             timeout_r;
   logic             timeout_n;
   logic             enter;
   logic             tick;
   logic             dur_done;
   logic             granted_live;
   logic             preempt;

   alarm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (enter),
      .tick (tick)
   );

   assign eligible     = bus.req & ~mute;
   assign winner       = N_REQ'(pri_onehot(MAX_REQ'(eligible)));
   assign granted_live = |(bus.req & grant);
   assign preempt      = (winner != '0) && (winner < grant);
   assign round_inc    = round_cnt + 1'b1;

   // End of the current timed phase on its last tick.
   always_comb begin
      dur_done = 1'b0;
      unique case (state)
         ST_ON:
            dur_done = tick &&
               (tick_cnt == TW'(ON_TICKS - 1));
         ST_OFF:
            dur_done = tick &&
               (tick_cnt == TW'(OFF_TICKS - 1));
         ST_GAP:
            dur_done = tick &&
               (tick_cnt == TW'(GAP_TICKS - 1));
         default:
            dur_done = 1'b0;
      endcase
   end

   // Next state, grant, counters, mute set and timeout.
   always_comb begin
      state_n     = state;
      grant_n     = grant;
      burst_cnt_n = burst_cnt;
      round_cnt_n = round_cnt;
      timeout_n   = timeout_r;
      mute_set    = '0;
      enter       = 1'b0;
      tick_cnt_n  = tick ? tick_cnt + 1'b1 : tick_cnt;

      if (state == ST_IDLE) begin
         tick_cnt_n = '0;
         if (bus.ack) begin
            timeout_n = 1'b0;
         end
         if (eligible != '0) begin
            state_n     = ST_ON;
            grant_n     = winner;
            burst_cnt_n = '0;
            round_cnt_n = '0;
            timeout_n   = 1'b0;
            enter       = 1'b1;
         end
      end else if (bus.ack) begin
         state_n   = ST_IDLE;
         grant_n   = '0;
         mute_set  = grant;
         timeout_n = 1'b0;
         enter     = 1'b1;
      end else if (!granted_live) begin
         state_n = ST_IDLE;
         grant_n = '0;
         enter   = 1'b1;
      end else if (preempt) begin
         state_n     = ST_ON;
         grant_n     = winner;
         burst_cnt_n = '0;
         round_cnt_n = '0;
         timeout_n   = 1'b0;
         enter       = 1'b1;
      end else if (dur_done) begin
         enter = 1'b1;
         unique case (state)
            ST_ON: begin
               if (burst_cnt < BW'(BURSTS - 1)) begin
                  state_n     = ST_OFF;
                  burst_cnt_n = burst_cnt + 1'b1;
               end else begin
                  state_n = ST_GAP;
               end
            end
            ST_OFF: begin
               state_n = ST_ON;
            end
            ST_GAP: begin
               burst_cnt_n = '0;
               round_cnt_n = round_inc;
               if (round_inc == RW'(MAX_ROUNDS)) begin
                  state_n   = ST_IDLE;
                  grant_n   = '0;
                  mute_set  = grant;
                  timeout_n = 1'b1;
               end else begin
                  state_n = ST_ON;
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase
      end

      if (enter) begin
         tick_cnt_n = '0;
      end
   end

   // State, counters, mute mask and sticky timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         mute      <= '0;
         tick_cnt  <= '0;
         burst_cnt <= '0;
         round_cnt <= '0;
         timeout_r <= 1'b0;
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         mute      <= (mute | mute_set) & bus.req;
         tick_cnt  <= tick_cnt_n;
         burst_cnt <= burst_cnt_n;
         round_cnt <= round_cnt_n;
         timeout_r <= timeout_n;
      end
   end

   assign bus.alarm_en = (state == ST_ON);
   assign bus.light_en = (state != ST_IDLE);
   assign bus.busy     = (state != ST_IDLE);
   assign bus.grant    = grant;
   assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: table-driven check of cadence,
// priority, ack, timeout and reset behaviour.
module tb_alarm_sequencer;

  import alarm_pkg::*;

  localparam int N = 3;

  typedef struct {
    int         scn;
    int         cyc;
    logic [2:0] req;
    logic       ack;
    logic       rst;
    logic       chk;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  alarm_if #(.N_REQ(N)) bus ();

  alarm_sequencer #(
    .N_REQ      (N),
    .TICK_DIV   (4),
    .ON_TICKS   (2),
    .OFF_TICKS  (1),
    .BURSTS     (2),
    .GAP_TICKS  (3),
    .MAX_ROUNDS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_inv = 0;
  int   cyc   = 0;
  int   cur   = -1;

  function automatic logic [6:0] o(
    input logic       ae,
    input logic       le,
    input logic [2:0] gr,
    input logic       bz,
    input logic       to
  );
    return {ae, le, gr, bz, to};
  endfunction

  function automatic vec_t mk(
    input int         s,
    input int         c,
    input logic [2:0] r,
    input logic       a,
    input logic       x,
    input logic       k,
    input logic [6:0] e
  );
    vec_t v;
    v.scn = s;
    v.cyc = c;
    v.req = r;
    v.ack = a;
    v.rst = x;
    v.chk = k;
    v.exp = e;
    return v;
  endfunction

  function automatic logic s1_on(input int t);
    int p;
    p = (t - 1) % 32;
    return (p < 8) || (p >= 12 && p < 20);
  endfunction

  task automatic add(
    input int         s,
    input int         c,
    input logic [2:0] r,
    input logic       a,
    input logic       x,
    input logic [6:0] e
  );
    tbl.push_back(mk(s, c, r, a, x, 1'b1, e));
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.alarm_en && !bus.light_en) begin
      n_inv++;
      $display("FAIL inv: alarm_en without light_en");
    end
    if (bus.busy !== bus.light_en) begin
      n_inv++;
      $display("FAIL inv: busy %b light_en %b",
        bus.busy, bus.light_en);
    end
    if ((bus.grant & (bus.grant - 1'b1)) != '0) begin
      n_inv++;
      $display("FAIL inv: grant %b not one-hot",
        bus.grant);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] z;
    logic [6:0] act;
    vec_t       e;

    rst     = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    z       = '0;

    add(1, 0, 3'b001, 0, 0, z);
    for (int t = 1; t <= 64; t++) begin
      add(1, t, 3'b001, 0, 0,
        o(s1_on(t), 1, 3'b001, 1, 0));
    end
    add(1, 65, 3'b001, 0, 0, o(0, 0, 3'b000, 0, 1));
    add(1, 70, 3'b001, 0, 0, o(0, 0, 3'b000, 0, 1));
    add(1, 80, 3'b000, 0, 0, o(0, 0, 3'b000, 0, 1));
    add(1, 81, 3'b001, 0, 0, o(0, 0, 3'b000, 0, 1));
    add(1, 82, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(1, 83, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));

    add(2, 0, 3'b001, 0, 0, z);
    add(2, 1, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(2, 5, 3'b001, 1, 0, o(1, 1, 3'b001, 1, 0));
    add(2, 6, 3'b001, 0, 0, z);
    add(2, 9, 3'b001, 0, 0, z);
    add(2, 10, 3'b000, 0, 0, z);
    add(2, 11, 3'b001, 0, 0, z);
    add(2, 12, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(2, 19, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(2, 20, 3'b001, 0, 0, o(0, 1, 3'b001, 1, 0));

    add(3, 0, 3'b100, 0, 0, z);
    add(3, 1, 3'b100, 0, 0, o(1, 1, 3'b100, 1, 0));
    add(3, 10, 3'b100, 0, 0, o(0, 1, 3'b100, 1, 0));
    add(3, 14, 3'b101, 0, 0, o(1, 1, 3'b100, 1, 0));
    add(3, 15, 3'b101, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(3, 22, 3'b101, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(3, 23, 3'b101, 0, 0, o(0, 1, 3'b001, 1, 0));
    add(3, 26, 3'b101, 0, 0, o(0, 1, 3'b001, 1, 0));
    add(3, 27, 3'b101, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(3, 28, 3'b100, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(3, 29, 3'b100, 0, 0, z);
    add(3, 30, 3'b100, 0, 0, o(1, 1, 3'b100, 1, 0));

    add(4, 0, 3'b011, 0, 0, z);
    add(4, 1, 3'b011, 0, 0, o(1, 1, 3'b001, 1, 0));
    add(4, 3, 3'b011, 1, 0, o(1, 1, 3'b001, 1, 0));
    add(4, 4, 3'b011, 0, 0, z);
    add(4, 5, 3'b011, 0, 0, o(1, 1, 3'b010, 1, 0));
    add(4, 12, 3'b011, 0, 0, o(1, 1, 3'b010, 1, 0));
    add(4, 13, 3'b011, 0, 0, o(0, 1, 3'b010, 1, 0));

    add(5, 0, 3'b001, 0, 0, z);
    add(5, 9, 3'b001, 0, 0, o(0, 1, 3'b001, 1, 0));
    add(5, 10, 3'b001, 0, 1, o(0, 1, 3'b001, 1, 0));
    add(5, 11, 3'b001, 0, 0, z);
    add(5, 12, 3'b001, 0, 0, o(1, 1, 3'b001, 1, 0));

    add(7, 0, 3'b010, 0, 0, z);
    add(7, 1, 3'b010, 0, 0, o(1, 1, 3'b010, 1, 0));
    add(7, 64, 3'b010, 0, 0, o(0, 1, 3'b010, 1, 0));
    add(7, 65, 3'b010, 0, 0, o(0, 0, 3'b000, 0, 1));
    add(7, 66, 3'b010, 1, 0, o(0, 0, 3'b000, 0, 1));
    add(7, 67, 3'b010, 0, 0, z);

    foreach (tbl[i]) begin
      if (tbl[i].scn != cur) begin
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        cur = tbl[i].scn;
      end
      if (tbl[i].chk) begin
        sb.push_back(tbl[i]);
      end
      while (cyc < tbl[i].cyc) begin
        @(negedge clk);
        bus.ack = 1'b0;
        rst     = 1'b0;
        cyc++;
      end
      if (tbl[i].chk) begin
        e   = sb.pop_front();
        act = {bus.alarm_en, bus.light_en, bus.grant,
               bus.busy, bus.timeout};
        n_vec++;
        if (act !== e.exp) begin
          n_bad++;
          $display(
            "FAIL s%0d c%0d {ae,le,gr,bz,to} got %b exp %b",
            e.scn, e.cyc, act, e.exp);
        end
      end
      bus.req = tbl[i].req;
      bus.ack = tbl[i].ack;
      rst     = tbl[i].rst;
    end

    @(negedge clk);
    bus.ack = 1'b0;
    rst     = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
      n_vec, n_bad);
    if (n_vec != tbl.size()) begin
      $display("FAIL only %0d of %0d vectors checked",
        n_vec, tbl.size());
    end
    if (n_bad != 0 || n_inv != 0) begin
      $display("FAIL %0d miscompares, %0d invariant errors",
        n_bad, n_inv);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
